spi_shift_engine: RTL and testbench
===================================

Name: spi_shift_engine

Overview:
Parameterised SPI serialiser/deserialiser and the next generation of the fixed 8-bit shift register. It takes a parallel word through a valid/ready load handshake and shifts it out MSB- or LSB-first in SPI mode 0. It assembles the received word, counts bits and emits a one-cycle rx_valid at word end. It sits between the SPI edge detectors (which produce serial-clock edge enables) and the SPI slave/master control FSM.

Parameters:
WIDTH, 8, word length in bits; legal range 2 to 32.
MSB_FIRST, 1, 1 = MSB shifted out and in first; 0 = LSB first.

Ports:
clk  input  1  system clock; all state changes on its posedge.
reset_n  input  1  asynchronous active-low reset.
sclk_rise  input  1  one-cycle enable marking a serial-clock rising edge (sample edge).
sclk_fall  input  1  one-cycle enable marking a serial-clock falling edge (shift edge).
abort  input  1  chip-select deassert; cancels any transfer in progress.
load_valid  input  1  parallel word offered.
load_data  input  WIDTH  word to transmit.
load_ready  output  1  engine can accept a word.
serial_in  input  1  MISO/MOSI receive bit.
serial_out  output  1  transmit bit.
rx_data  output  WIDTH  last completed received word.
rx_valid  output  1  one-cycle pulse when rx_data updates.
busy  output  1  transfer in progress.

Behaviour:
- Reset (asynchronous, reset_n=0): state=IDLE; shift reg, sample bit, bit count and rx_data all 0; serial_out=0, rx_valid=0, busy=0, load_ready=1.
- serial_out is combinational from the shift reg: shreg[WIDTH-1] if MSB_FIRST, else shreg[0].
- Bit counter width is clog2(WIDTH+1).
- States: IDLE, SHIFT, DONE.
- IDLE:
  - load_ready=1, busy=0.
  - load_valid=1 → shreg<=load_data, count<=0, go SHIFT next cycle. The first bit is therefore on serial_out before the first sclk_rise.
  - sclk_rise/sclk_fall are ignored.
- SHIFT:
  - load_ready=0, busy=1; load_valid is ignored (no overwrite).
  - sclk_rise: sample<=serial_in.
  - sclk_fall: MSB_FIRST → shreg<={shreg[WIDTH-2:0],sample}; else shreg<={sample,shreg[WIDTH-1:1]}. Then count<=count+1.
  - sclk_rise and sclk_fall in the same cycle: shift uses serial_in directly in place of sample, and sample is also updated. This counts as one bit.
  - On the shift making count reach WIDTH: rx_data<=shifted value, go DONE.
- DONE:
  - Lasts exactly one cycle: rx_valid=1, busy=1, load_ready=0. Then go IDLE.
  - Edge enables are ignored in DONE.
  - rx_data holds until the next completed word.
- Latency: rx_valid asserts the cycle after the WIDTH-th sclk_fall is registered. The next word can load 2 cycles after the final fall.
- abort=1, any state:
  - Next state IDLE; count<=0; rx_valid stays 0 and rx_data is not updated; shreg is retained.
  - abort has priority over load_valid and edge enables in the same cycle.
- Edge enables while abort is held are ignored.
- reset_n asserted mid-transfer: immediate return to reset values; no rx_valid.
- Width rules: count never exceeds WIDTH; no wrap is required.

Test Plan:
- Reset: drive reset_n low mid-cycle → outputs go to reset values immediately without a clk edge (load_ready=1, busy=0, serial_out=0, rx_data=0).
- Full duplex, WIDTH=8, MSB_FIRST=1: load 0xA5, serial_in stream 0x3C over 8 rise/fall pairs → serial_out sequence 1,0,1,0,0,1,0,1 (valid before each rise), rx_data=0x3C, rx_valid high exactly 1 cycle, busy low 2 cycles after the 8th fall.
- LSB first (MSB_FIRST=0), WIDTH=8: load 0x01, serial_in sequence 1,0,0,0,0,0,0,0 → serial_out 1 then 0s; rx_data=0x01.
- Abort: load 0xFF, abort after 3 falls → IDLE next cycle, no rx_valid, rx_data unchanged. A new load of 0x0F then transfers a full 8 bits correctly.
- Handshake/boundary: load_valid held during SHIFT → load_ready=0 and shreg unchanged. Coincident sclk_rise+sclk_fall with serial_in=1 → exactly one bit shifted, and that bit is 1.
- WIDTH=16: load 0x8001 with serial_in=serial_out loopback → rx_data=0x8001 after 16 falls.

Source files
------------

// File: rtl/spi_shift_engine_if.sv
// Parallel-side bundle of the SPI shift engine: load handshake plus the received word.
// The engine uses the slave view; the controlling FSM (or a bench) uses the master view.
interface spi_shift_engine_if #(
  parameter int WIDTH = 8
);
  logic             load_valid;
  logic [WIDTH-1:0] load_data;
  logic             load_ready;
  logic [WIDTH-1:0] rx_data;
  logic             rx_valid;
  logic             busy;

  modport master (
    output load_valid, load_data,
    input  load_ready, rx_data, rx_valid, busy
  );

  modport slave (
    input  load_valid, load_data,
    output load_ready, rx_data, rx_valid, busy
  );
endinterface

// File: rtl/spi_shift_engine.sv
// SPI mode-0 serialiser/deserialiser: loads a parallel word, shifts on serial-clock
// falls, samples on rises, and pulses rx_valid for one cycle when a word completes.
module spi_shift_engine #(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 sclk_rise,
  input  logic                 sclk_fall,
  input  logic                 abort,
  input  logic                 serial_in,
  output logic                 serial_out,
  spi_shift_engine_if.slave    bus
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shifted;
  logic             sample;
  logic             in_bit;
  logic [CW-1:0]    count;

  assign serial_out = (MSB_FIRST != 0) ? shreg[WIDTH-1] : shreg[0];

  // A coincident rise and fall shifts in the live serial_in, not the stale sample.
  // NOTE: always_comb gives every output a value on every path, so no latch is inferred.
  always_comb begin
    in_bit  = sclk_rise ? serial_in : sample;
    shifted = shreg;
    if (MSB_FIRST != 0) shifted = {shreg[WIDTH-2:0], in_bit};
    else                shifted = {in_bit, shreg[WIDTH-1:1]};
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      shreg          <= '0;
      sample         <= 1'b0;
      count          <= '0;
      bus.rx_data    <= '0;
      bus.rx_valid   <= 1'b0;
      bus.busy       <= 1'b0;
      bus.load_ready <= 1'b1;
    end else begin
      bus.rx_valid <= 1'b0;
      if (abort) begin
        // shreg is deliberately kept; only the transfer bookkeeping is cancelled
        state          <= IDLE;
        count          <= '0;
        bus.busy       <= 1'b0;
        bus.load_ready <= 1'b1;
      end else begin
        unique case (state)
          IDLE: begin
            if (bus.load_valid) begin
              shreg          <= bus.load_data;
              count          <= '0;
              state          <= SHIFT;
              bus.busy       <= 1'b1;
              bus.load_ready <= 1'b0;
            end
          end
          SHIFT: begin
            if (sclk_rise) sample <= serial_in;
            if (sclk_fall) begin
              shreg <= shifted;
              count <= count + CW'(1);
              if (count == LAST_BIT) begin
                bus.rx_data  <= shifted;
                bus.rx_valid <= 1'b1;
                state        <= DONE;
              end
            end
          end
          DONE: begin
            state          <= IDLE;
            bus.busy       <= 1'b0;
            bus.load_ready <= 1'b1;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_spi_shift_engine.sv
// Directed bench for spi_shift_engine: three instances (8-bit MSB-first, 8-bit
// LSB-first, 16-bit MSB-first) driven one at a time with hand-computed vectors.
module tb_spi_shift_engine;
  logic clk;
  logic reset_n;
  logic rise [3];
  logic fall [3];
  logic ab   [3];
  logic sin  [3];
  logic sout [3];

  int checks   = 0;
  int failures = 0;

  spi_shift_engine_if #(.WIDTH(8))  if8m ();
  spi_shift_engine_if #(.WIDTH(8))  if8l ();
  spi_shift_engine_if #(.WIDTH(16)) if16 ();

  spi_shift_engine #(.WIDTH(8), .MSB_FIRST(1)) u_m8 (
    .clk(clk), .reset_n(reset_n), .sclk_rise(rise[0]), .sclk_fall(fall[0]),
    .abort(ab[0]), .serial_in(sin[0]), .serial_out(sout[0]), .bus(if8m.slave));
  spi_shift_engine #(.WIDTH(8), .MSB_FIRST(0)) u_l8 (
    .clk(clk), .reset_n(reset_n), .sclk_rise(rise[1]), .sclk_fall(fall[1]),
    .abort(ab[1]), .serial_in(sin[1]), .serial_out(sout[1]), .bus(if8l.slave));
  spi_shift_engine #(.WIDTH(16), .MSB_FIRST(1)) u_m16 (
    .clk(clk), .reset_n(reset_n), .sclk_rise(rise[2]), .sclk_fall(fall[2]),
    .abort(ab[2]), .serial_in(sin[2]), .serial_out(sout[2]), .bus(if16.slave));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_load(input int d, input logic v, input logic [15:0] data);
    case (d)
      0:       begin if8m.load_valid = v; if8m.load_data = data[7:0]; end
      1:       begin if8l.load_valid = v; if8l.load_data = data[7:0]; end
      default: begin if16.load_valid = v; if16.load_data = data;      end
    endcase
  endtask

  function automatic logic [15:0] rx_of(input int d);
    case (d)
      0:       return {8'h00, if8m.rx_data};
      1:       return {8'h00, if8l.rx_data};
      default: return if16.rx_data;
    endcase
  endfunction

  function automatic logic [2:0] flags_of(input int d); // {rx_valid, busy, load_ready}
    case (d)
      0:       return {if8m.rx_valid, if8m.busy, if8m.load_ready};
      1:       return {if8l.rx_valid, if8l.busy, if8l.load_ready};
      default: return {if16.rx_valid, if16.busy, if16.load_ready};
    endcase
  endfunction

  task automatic cyc(input int d, input logic r, input logic f, input logic s);
    rise[d] = r;
    fall[d] = f;
    sin[d]  = s;
    step();
    rise[d] = 1'b0;
    fall[d] = 1'b0;
  endtask

  task automatic load(input int d, input logic [15:0] data);
    set_load(d, 1'b1, data);
    step();
    set_load(d, 1'b0, 16'h0);
  endtask

  // Full transfer: tx bits must appear on serial_out before each rise; rxw is the word
  // presented bit by bit on serial_in (or serial_out itself when loop is set).
  task automatic xfer(input int d, input int w, input bit msb, input logic [15:0] tx,
                      input logic [15:0] rxw, input bit loop, input string tag);
    int idx;
    load(d, tx);
    check({tag, "_flags_load"}, 32'(flags_of(d)), 32'b010);
    for (int i = 0; i < w; i++) begin
      idx = msb ? (w - 1 - i) : i;
      check($sformatf("%s_sout%0d", tag, i), 32'(sout[d]), 32'(tx[idx]));
      cyc(d, 1'b1, 1'b0, loop ? sout[d] : rxw[idx]);
      if (i == w - 1) check({tag, "_novalid_early"}, 32'(flags_of(d)), 32'b010);
      cyc(d, 1'b0, 1'b1, 1'b0);
    end
    check({tag, "_flags_done"}, 32'(flags_of(d)), 32'b110);
    check({tag, "_rx"}, 32'(rx_of(d)), 32'(rxw));
    step();
    check({tag, "_flags_idle"}, 32'(flags_of(d)), 32'b001);
  endtask

  initial begin
    reset_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rise[i] = 1'b0; fall[i] = 1'b0; ab[i] = 1'b0; sin[i] = 1'b0;
      set_load(i, 1'b0, 16'h0);
    end
    #12;
    check("rst_flags", 32'(flags_of(0)), 32'b001);
    check("rst_sout",  32'(sout[0]), 32'd0);
    check("rst_rx",    32'(rx_of(0)), 32'h0);
    reset_n = 1'b1;
    step();

    // Full duplex, MSB first
    xfer(0, 8, 1'b1, 16'h00A5, 16'h003C, 1'b0, "md");
    step();
    check("md_rxhold", 32'(rx_of(0)), 32'h3C);

    // Abort after 3 falls; the abort cycle also carries edges, which must be ignored
    load(0, 16'h00FF);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1'b1, 1'b0, 1'b0);
      cyc(0, 1'b0, 1'b1, 1'b0);
    end
    ab[0] = 1'b1;
    cyc(0, 1'b1, 1'b1, 1'b0);
    ab[0] = 1'b0;
    check("ab_flags", 32'(flags_of(0)), 32'b001);
    check("ab_rx",    32'(rx_of(0)), 32'h3C);
    check("ab_sout",  32'(sout[0]), 32'd1);
    step();
    check("ab_flags2", 32'(flags_of(0)), 32'b001);
    xfer(0, 8, 1'b1, 16'h000F, 16'h0096, 1'b0, "ab_new");

    // load_valid held during SHIFT with a different word: must not overwrite
    load(0, 16'h00A5);
    set_load(0, 1'b1, 16'h0000);
    step();
    check("hs_ready", 32'(flags_of(0)), 32'b010);
    check("hs_sout",  32'(sout[0]), 32'd1);
    step();
    set_load(0, 1'b0, 16'h0000);
    // Coincident rise+fall with serial_in=1 counts as one bit, value 1
    cyc(0, 1'b1, 1'b1, 1'b1);
    check("co_sout1", 32'(sout[0]), 32'd0);
    for (int i = 0; i < 7; i++) begin
      cyc(0, 1'b1, 1'b0, 1'b0);
      if (i == 6) check("co_notdone", 32'(flags_of(0)), 32'b010);
      cyc(0, 1'b0, 1'b1, 1'b0);
    end
    check("co_flags", 32'(flags_of(0)), 32'b110);
    check("co_rx",    32'(rx_of(0)), 32'h80);
    step();

    // Asynchronous reset mid-transfer, asserted between clock edges
    load(0, 16'h00A5);
    cyc(0, 1'b1, 1'b0, 1'b1);
    cyc(0, 1'b0, 1'b1, 1'b0);
    cyc(0, 1'b1, 1'b0, 1'b1);
    cyc(0, 1'b0, 1'b1, 1'b0);
    check("ar_pre_sout", 32'(sout[0]), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("ar_flags", 32'(flags_of(0)), 32'b001);
    check("ar_sout",  32'(sout[0]), 32'd0);
    check("ar_rx",    32'(rx_of(0)), 32'h0);
    #3 reset_n = 1'b1;
    step();
    check("ar_after", 32'(flags_of(0)), 32'b001);

    // LSB first
    xfer(1, 8, 1'b0, 16'h0001, 16'h0001, 1'b0, "lsb");
    xfer(1, 8, 1'b0, 16'h00C2, 16'h0035, 1'b0, "lsb2");

    // 16-bit loopback
    xfer(2, 16, 1'b1, 16'h8001, 16'h8001, 1'b1, "w16");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
